// File: rtl/unidade_controle.sv
// unidade_controle: 4-state fetch/decode/execute/write-back control unit driving an 8x16 register file.
// Optional status flags are built when UC_FLAGS_EN is defined; otherwise flag_z/n/c are tied to 0.
module unidade_controle (
  input  logic        clock,
  input  logic        resetn,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  Read1,
  output logic [2:0]  Read2,
  input  logic [15:0] Data1,
  input  logic [15:0] Data2,
  output logic [2:0]  WriteReg,
  output logic [15:0] WriteData,
  output logic        RegWrite,
  output logic        done,
  output logic        illegal,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WRITE} state_t;
  state_t state;
  logic [15:0] ir;
  logic [3:0] op;
  logic is_sub;
  logic [15:0] b_op;
  logic [15:0] add_res;
  logic [15:0] alu;
  assign op = ir[15:12];
  assign Read1 = ir[8:6];
  assign Read2 = ir[5:3];
  assign WriteReg = ir[11:9];
  assign is_sub = op == 4'd4;
  // SUB shares the adder as rs1 + ~rs2 + 1
  assign b_op = is_sub ? ~Data2 : Data2;
  assign add_res = Data1 + b_op + {15'd0, is_sub};
  always_comb begin
    alu = op == 4'd1 ? Data1 :
          op == 4'd2 ? {{7{ir[8]}}, ir[8:0]} :
          (op == 4'd3 || op == 4'd4) ? add_res :
          op == 4'd5 ? Data1 & Data2 :
          op == 4'd6 ? Data1 | Data2 :
          op == 4'd7 ? Data1 ^ Data2 :
          op == 4'd8 ? Data1 << Data2[3:0] :
          op == 4'd9 ? Data1 >> Data2[3:0] : 16'd0;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ir <= '0;
      WriteData <= '0;
      RegWrite <= 1'b0;
      done <= 1'b0;
      illegal <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          ir <= instr;
          state <= DECODE;
          instr_ready <= 1'b0;
        end
        DECODE: state <= EXEC;
        EXEC: begin
          state <= WRITE;
          WriteData <= alu;
          RegWrite <= op != 4'd0 && op <= 4'd9;
          done <= 1'b1;
          illegal <= op > 4'd9;
        end
        default: begin
          state <= IDLE;
          RegWrite <= 1'b0;
          done <= 1'b0;
          illegal <= 1'b0;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end
`ifdef UC_FLAGS_EN
  logic [16:0] sum17;
  assign sum17 = {1'b0, Data1} + {1'b0, b_op} + {16'd0, is_sub};
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (state == EXEC && op >= 4'd3 && op <= 4'd9) begin
      flag_z <= alu == 16'd0;
      flag_n <= alu[15];
      flag_c <= (op == 4'd3 || is_sub) && sum17[16];
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
`endif
endmodule
